eth_frame_detector: RTL and testbench
=====================================

# eth_frame_detector

Receive-side parser placed directly on the AXI4-Stream output of a TEMAC, upstream of the latency measurer's result logic. Checks each received frame against the measurement-frame format (destination MAC, EtherType, identifier) and extracts its 64-bit sequence number. For every frame it emits a one-cycle result carrying match status, sequence, start-of-frame timestamp and byte length. It also keeps matched and mismatched frame counters.

## Interface
Parameters:
- `dest_mac`, 48'hDE_AD_BE_EF_01_02: required destination MAC, bytes 0-5, MSB first.
- `ethertype`, 16'h88B5: required EtherType, bytes 12-13.
- `identifier`, 32'hCAFECAFE: required identifier, bytes 14-17, MSB first.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock for all logic.
  - `rst`  in  1  synchronous reset, active-high.
- Control and time:
  - `enable`  in  1  when low, frames starting are ignored (no result, no count).
  - `current_time`  in  64  free-running timestamp.
- Input stream (no tready; the TEMAC RX cannot be stalled):
  - `s_axis_tdata`  in  8  frame byte.
  - `s_axis_tkeep`  in  1  byte valid.
  - `s_axis_tlast`  in  1  last byte of frame.
  - `s_axis_tvalid`  in  1  beat valid.
- Result outputs:
  - `det_valid`  out  1  one-cycle result strobe.
  - `det_match`  out  1  frame matched all header checks.
  - `det_seq`  out  64  bytes 18-25, MSB first; 0 if not captured.
  - `det_time`  out  64  `current_time` at the frame's first beat.
  - `det_length`  out  11  bytes received, saturating at 2047.
- Counters:
  - `match_count`  out  32  matched frames, wraps.
  - `mismatch_count`  out  32  mismatched frames, wraps.

## Operation
- Beat definition: a beat is a cycle with `s_axis_tvalid` = 1. `s_axis_tkeep` = 0 beats are counted like any other (the TEMAC always drives 1).
- States:
  - IDLE
    - First beat with `enable` = 1: latch `current_time`, byte count = 1, clear `match_ok` (internal, set to 1), clear seq, check byte 0, go to HEADER.
    - First beat with `enable` = 0: go to DISCARD.
  - HEADER (byte count 1..25)
    - Compare byte n with the expected constant. Any mismatch clears `match_ok`.
    - Bytes 6-11 (source MAC) are ignored.
    - Bytes 18-25 shift into seq.
    - After byte 25, go to PAYLOAD.
  - PAYLOAD: count bytes only.
  - DISCARD: wait for a `tlast` beat, then go to IDLE. Produces no output.
- Frame end: a `tlast` beat in HEADER or PAYLOAD ends the frame.
  - Next cycle: `det_valid` = 1.
  - `det_match` = `match_ok` AND (length ≥ 26).
  - Increment the matching counter.
  - Return to IDLE.
  - A `tlast` on the first beat in IDLE ends a 1-byte frame: mismatch, length 1.
- Short frames: a frame with fewer than 26 bytes is a mismatch; `det_seq` holds the partially shifted value.
- Byte count saturates at 2047; the state machine keeps working.
- `enable` is sampled only at frame start. Deasserting mid-frame does not abort the frame.

## Timing
- Reset values: all outputs 0; state IDLE.
- Result latency: `det_valid` asserts exactly 1 cycle after the `tlast` beat and stays high for 1 cycle.
  - `det_*` hold their values until the next result.
  - Counters update in the same cycle `det_valid` rises.
- Back-to-back frames: a new first beat on the cycle right after `tlast` is accepted (IDLE is reached in the same cycle the result registers). Throughput is 1 byte/cycle with zero gap.
- Cycles with `tvalid` = 0 inside a frame are ignored; state and count are held.
- Timestamp is `current_time` as sampled on the first beat's cycle.
- Counter wrap: 32'hFFFFFFFF + 1 = 0.
- Reset mid-frame: the frame is abandoned with no result. Remaining beats of that frame are parsed as a new frame starting at whatever byte arrives next.

## Test plan
- Valid 64-byte frame, seq 64'h0000_0000_0000_0005, first beat at `current_time` = 1000 → one `det_valid` 1 cycle after `tlast`; `det_match` = 1, `det_seq` = 5, `det_time` = 1000, `det_length` = 64, `match_count` = 1.
- Same frame with byte 3 = 8'h00 (wrong dest MAC) → `det_match` = 0, `mismatch_count` = 1, `match_count` unchanged.
- 20-byte frame with correct first 18 bytes → `det_match` = 0, `det_length` = 20.
- Two valid 60-byte frames back-to-back with zero gap, random `tvalid` gaps inside the second → two results, seqs correct, `det_length` = 60 each.
- `enable` = 0 at the start of frame A, raised mid-A; frame B follows → only B produces a result; counters total 1.
- `rst` pulsed at byte 10 of a frame, followed by the rest of that frame and then a valid frame → outputs 0 during reset; trailing bytes give a mismatch result; the valid frame matches.

Source files
------------

// File: rtl/eth_frame_detector_if.sv
// rtl/eth_frame_detector_if.sv - byte-wide receive stream from the TEMAC (no back-pressure)
interface eth_frame_detector_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tkeep;
    logic       s_axis_tlast;
    logic       s_axis_tvalid;

    modport master (output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid);
    modport slave  (input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid);
endinterface

// File: rtl/eth_frame_detector.sv
// rtl/eth_frame_detector.sv - measurement-frame header checker and sequence extractor
module eth_frame_detector #(
    parameter logic [47:0] dest_mac   = 48'hDE_AD_BE_EF_01_02,
    parameter logic [15:0] ethertype  = 16'h88B5,
    parameter logic [31:0] identifier = 32'hCAFECAFE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [63:0]                current_time,
    eth_frame_detector_if.slave        rx,
    output logic                       det_valid,
    output logic                       det_match,
    output logic [63:0]                det_seq,
    output logic [63:0]                det_time,
    output logic [10:0]                det_length,
    output logic [31:0]                match_count,
    output logic [31:0]                mismatch_count
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

    state_t      state, state_next;
    logic [10:0] count, count_next, byte_idx;
    logic        match_ok, match_ok_next;
    logic [63:0] seq, seq_next, start_time;
    logic        beat, start_new, parse, frame_end;
    logic        unused_tkeep;

    // The TEMAC always drives tkeep high; empty beats are counted anyway.
    assign unused_tkeep = rx.s_axis_tkeep;
    assign beat         = rx.s_axis_tvalid;

    function automatic logic byte_ok(input logic [10:0] idx, input logic [7:0] b);
        case (idx)
            11'd0:   return b == dest_mac[47:40];
            11'd1:   return b == dest_mac[39:32];
            11'd2:   return b == dest_mac[31:24];
            11'd3:   return b == dest_mac[23:16];
            11'd4:   return b == dest_mac[15:8];
            11'd5:   return b == dest_mac[7:0];
            11'd12:  return b == ethertype[15:8];
            11'd13:  return b == ethertype[7:0];
            11'd14:  return b == identifier[31:24];
            11'd15:  return b == identifier[23:16];
            11'd16:  return b == identifier[15:8];
            11'd17:  return b == identifier[7:0];
            default: return 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat) state_next = rx.s_axis_tlast ? IDLE : (enable ? HEADER : DISCARD);
            HEADER:  if (beat) begin
                         if (rx.s_axis_tlast)      state_next = IDLE;
                         else if (count == 11'd25) state_next = PAYLOAD;
                     end
            PAYLOAD: if (beat && rx.s_axis_tlast) state_next = IDLE;
            DISCARD: if (beat && rx.s_axis_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_new = beat && (state == IDLE) && enable;
        parse     = start_new || (beat && (state == HEADER || state == PAYLOAD));
        frame_end = parse && rx.s_axis_tlast;
    end

    // count holds the number of bytes seen so far, which is also the index of the incoming byte.
    always_comb begin
        byte_idx      = start_new ? 11'd0 : count;
        count_next    = start_new ? 11'd1 : ((count == 11'd2047) ? count : count + 11'd1);
        match_ok_next = (start_new ? 1'b1 : match_ok) & byte_ok(byte_idx, rx.s_axis_tdata);
        seq_next      = start_new ? 64'd0 : seq;
        if (byte_idx >= 11'd18 && byte_idx <= 11'd25)
            seq_next = {seq[55:0], rx.s_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            match_ok       <= 1'b0;
            seq            <= '0;
            start_time     <= '0;
            det_valid      <= 1'b0;
            det_match      <= 1'b0;
            det_seq        <= '0;
            det_time       <= '0;
            det_length     <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
        end else begin
            det_valid <= frame_end;
            if (parse) begin
                count    <= count_next;
                match_ok <= match_ok_next;
                seq      <= seq_next;
            end
            if (start_new)
                start_time <= current_time;
            if (frame_end) begin
                det_match  <= match_ok_next && (count_next >= 11'd26);
                det_seq    <= seq_next;
                det_time   <= start_new ? current_time : start_time;
                det_length <= count_next;
                if (match_ok_next && (count_next >= 11'd26)) match_count    <= match_count + 32'd1;
                else                                         mismatch_count <= mismatch_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_detector.sv
// tb/tb_eth_frame_detector.sv - directed frame vectors plus back-to-back, enable and reset sequences
module tb_eth_frame_detector;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [63:0] current_time;
    logic        det_valid, det_match;
    logic [63:0] det_seq, det_time;
    logic [10:0] det_length;
    logic [31:0] match_count, mismatch_count;

    eth_frame_detector_if bus();

    eth_frame_detector dut (
        .clk(clk), .rst(rst), .enable(enable), .current_time(current_time), .rx(bus),
        .det_valid(det_valid), .det_match(det_match), .det_seq(det_seq), .det_time(det_time),
        .det_length(det_length), .match_count(match_count), .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic m; logic [63:0] s; logic [63:0] t; logic [10:0] l; } res_t;
    res_t resq[$];
    always @(negedge clk) if (det_valid) resq.push_back('{cyc, det_match, det_seq, det_time, det_length});

    typedef struct {
        int len; logic [63:0] seq; int bad; bit en0; logic [63:0] t0;
        bit exp_valid; bit exp_match; logic [10:0] exp_len; logic [63:0] exp_seq;
    } vec_t;

    int          nvec = 0, nfail = 0;
    logic [31:0] exp_mc = 0, exp_mm = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int idx, input logic [63:0] seq, input int bad);
        logic [47:0] mac = 48'hDEADBEEF0102;
        logic [31:0] id  = 32'hCAFECAFE;
        if (idx == bad)      return 8'h00;
        if (idx < 6)         return mac[8*(5-idx) +: 8];
        if (idx < 12)        return 8'h5A;
        if (idx == 12)       return 8'h88;
        if (idx == 13)       return 8'hB5;
        if (idx < 18)        return id[8*(17-idx) +: 8];
        if (idx < 26)        return seq[8*(25-idx) +: 8];
        return idx[7:0];
    endfunction

    task automatic drive_frame(input int len, input int from, input int to, input logic [63:0] seq,
                               input int bad, input bit en0, input int en_rise, input bit gaps,
                               input logic [63:0] t0, output int last_cyc);
        last_cyc = 0;
        for (int i = from; i <= to; i++) begin
            if (gaps && i > from) begin
                int n = $urandom_range(0, 2);
                repeat (n) begin @(negedge clk); bus.s_axis_tvalid = 1'b0; end
            end
            @(negedge clk);
            bus.s_axis_tdata  = byte_of(i, seq, bad);
            bus.s_axis_tkeep  = 1'b1;
            bus.s_axis_tlast  = (i == len - 1);
            bus.s_axis_tvalid = 1'b1;
            enable            = (i < en_rise) ? en0 : 1'b1;
            current_time      = t0 + 64'(i);
            last_cyc          = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input int last_cyc, input bit m,
                                input logic [63:0] s, input logic [63:0] t, input logic [10:0] l);
        res_t r;
        chk({tag, ".present"}, 64'(resq.size() != 0), 64'd1);
        if (resq.size() != 0) begin
            r = resq.pop_front();
            chk({tag, ".latency"}, 64'(r.c), 64'(last_cyc + 1));
            chk({tag, ".match"},   64'(r.m), 64'(m));
            chk({tag, ".seq"},     r.s, s);
            chk({tag, ".time"},    r.t, t);
            chk({tag, ".length"},  64'(r.l), 64'(l));
        end
        if (m) exp_mc++; else exp_mm++;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, ".match_count"},    64'(match_count),    64'(exp_mc));
        chk({tag, ".mismatch_count"}, 64'(mismatch_count), 64'(exp_mm));
    endtask

    vec_t vecs[11];
    int   lc, lc2;

    initial begin
        vecs[0]  = '{64,   64'h5,                   -1, 1, 64'd1000, 1, 1, 11'd64,   64'h5};
        vecs[1]  = '{64,   64'h5,                    3, 1, 64'd1100, 1, 0, 11'd64,   64'h5};
        vecs[2]  = '{20,   64'h1122334455667788,    -1, 1, 64'd1200, 1, 0, 11'd20,   64'h1122};
        vecs[3]  = '{26,   64'hA5A50F0F3C3C9696,    -1, 1, 64'd1300, 1, 1, 11'd26,   64'hA5A50F0F3C3C9696};
        vecs[4]  = '{25,   64'h0102030405060708,    -1, 1, 64'd1400, 1, 0, 11'd25,   64'h0001020304050607};
        vecs[5]  = '{1,    64'h77,                  -1, 1, 64'd1500, 1, 0, 11'd1,    64'h0};
        vecs[6]  = '{40,   64'hFEDCBA9876543210,    13, 1, 64'd1600, 1, 0, 11'd40,   64'hFEDCBA9876543210};
        vecs[7]  = '{40,   64'hFEDCBA9876543210,    17, 1, 64'd1700, 1, 0, 11'd40,   64'hFEDCBA9876543210};
        vecs[8]  = '{40,   64'h0123456789ABCDEF,     8, 1, 64'd1800, 1, 1, 11'd40,   64'h0123456789ABCDEF};
        vecs[9]  = '{30,   64'h42,                  -1, 0, 64'd1850, 0, 0, 11'd0,    64'h0};
        vecs[10] = '{2100, 64'hDEAD0000BEEF0001,    -1, 1, 64'd1900, 1, 1, 11'd2047, 64'hDEAD0000BEEF0001};

        rst = 1'b1; enable = 1'b0; current_time = '0;
        bus.s_axis_tdata = '0; bus.s_axis_tkeep = 1'b0; bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.det_valid",  64'(det_valid),  64'd0);
        chk("reset.det_match",  64'(det_match),  64'd0);
        chk("reset.det_seq",    det_seq,         64'd0);
        chk("reset.det_time",   det_time,        64'd0);
        chk("reset.det_length", 64'(det_length), 64'd0);
        check_counters("reset");
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            string tag = $sformatf("vec%0d", v);
            resq.delete();
            drive_frame(vecs[v].len, 0, vecs[v].len - 1, vecs[v].seq, vecs[v].bad,
                        vecs[v].en0, vecs[v].len, 1'b0, vecs[v].t0, lc);
            idle(3);
            if (vecs[v].exp_valid)
                check_result(tag, lc, vecs[v].exp_match, vecs[v].exp_seq, vecs[v].t0, vecs[v].exp_len);
            chk({tag, ".results"}, 64'(resq.size()), 64'd0);
            check_counters(tag);
        end

        // Zero-gap back-to-back frames, second one with idle beats sprinkled inside.
        resq.delete();
        drive_frame(60, 0, 59, 64'hAAAA000000000001, -1, 1, 0, 1'b0, 64'd5000, lc);
        drive_frame(60, 0, 59, 64'hBBBB000000000002, -1, 1, 0, 1'b1, 64'd6000, lc2);
        idle(3);
        chk("b2b.results", 64'(resq.size()), 64'd2);
        check_result("b2b.a", lc,  1'b1, 64'hAAAA000000000001, 64'd5000, 11'd60);
        check_result("b2b.b", lc2, 1'b1, 64'hBBBB000000000002, 64'd6000, 11'd60);
        check_counters("b2b");

        // Frame A starts while disabled; enable rises mid-frame and must not revive it.
        resq.delete();
        drive_frame(40, 0, 39, 64'hCCCC000000000003, -1, 0, 5, 1'b0, 64'd7000, lc);
        drive_frame(60, 0, 59, 64'hDDDD000000000004, -1, 1, 0, 1'b0, 64'd8000, lc2);
        idle(3);
        chk("enable.results", 64'(resq.size()), 64'd1);
        check_result("enable.b", lc2, 1'b1, 64'hDDDD000000000004, 64'd8000, 11'd60);
        check_counters("enable");

        // Reset lands on byte 10; bytes 11..63 then form a 53-byte mismatching frame.
        resq.delete();
        drive_frame(64, 0, 9, 64'hEEEE000000000005, -1, 1, 0, 1'b0, 64'd9000, lc);
        @(negedge clk);
        rst = 1'b1;
        bus.s_axis_tdata = byte_of(10, 64'hEEEE000000000005, -1);
        bus.s_axis_tlast = 1'b0; bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.s_axis_tvalid = 1'b0;
        chk("rst.det_valid",  64'(det_valid),  64'd0);
        chk("rst.det_seq",    det_seq,         64'd0);
        chk("rst.det_length", 64'(det_length), 64'd0);
        exp_mc = 0; exp_mm = 0;
        check_counters("rst");
        drive_frame(64, 11, 63, 64'hEEEE000000000005, -1, 1, 0, 1'b0, 64'd9000, lc);
        drive_frame(60, 0, 59, 64'hFFFF000000000006, -1, 1, 0, 1'b0, 64'd9500, lc2);
        idle(3);
        chk("rst.results", 64'(resq.size()), 64'd2);
        check_result("rst.tail",  lc,  1'b0, 64'h1D1E1F2021222324, 64'd9011, 11'd53);
        check_result("rst.valid", lc2, 1'b1, 64'hFFFF000000000006, 64'd9500, 11'd60);
        check_counters("rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
